// File: rtl/commit_trace_fifo.sv
// commit_trace_fifo: packs core register write-backs and data-memory accesses
// into trace records and queues them in a show-ahead FIFO. The core is never
// stalled. Records that do not fit are dropped and counted in a saturating counter.
// Optional feature: define TRACE_LOAD_EN to also record loads (kind 2'b10).
module commit_trace_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       reg_write_sig,
  input  logic [4:0]                 reg_num,
  input  logic [DATA_W-1:0]          reg_data,
  input  logic                       wr,
  input  logic                       rd,
  input  logic [ADDR_W-1:0]          addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [DATA_W-1:0]          rd_data,
  output logic                       trc_valid,
  input  logic                       trc_ready,
  output logic [1:0]                 trc_kind,
  output logic [ADDR_W-1:0]          trc_tag,
  output logic [DATA_W-1:0]          trc_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [15:0]                drop_cnt
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [1:0]        kind;
    logic [ADDR_W-1:0] tag;
    logic [DATA_W-1:0] data;
  } rec_t;

  rec_t          mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;

  logic          reg_cand;
  logic          mem_cand;
  rec_t          reg_rec;
  rec_t          mem_rec;
  rec_t          rec0;
  logic          pop;
  logic [CW-1:0] ncand;
  logic [CW-1:0] free;
  logic [CW-1:0] npush;
  logic [CW-1:0] ndrop;
  logic [16:0]   drop_sum;

`ifndef TRACE_LOAD_EN
  // Load-side inputs exist for port compatibility only in this build.
  logic unused_load;
  assign unused_load = &{1'b0, rd, rd_data};
`endif

  // Show-ahead head and occupancy flags derived from registered state.
  assign empty     = (count == CW'(0));
  assign full      = (count == CW'(DEPTH));
  assign trc_valid = !empty;
  assign trc_kind  = mem[rptr].kind;
  assign trc_tag   = mem[rptr].tag;
  assign trc_data  = mem[rptr].data;
  assign pop       = trc_valid & trc_ready;

  // Candidate detection, free-space arbitration and drop accounting.
  always_comb begin
    reg_cand     = reg_write_sig && (reg_num != 5'd0);
    reg_rec.kind = 2'b00;
    reg_rec.tag  = ADDR_W'(reg_num);
    reg_rec.data = reg_data;
`ifdef TRACE_LOAD_EN
    mem_cand     = wr | rd;
    mem_rec.kind = wr ? 2'b01 : 2'b10;
    mem_rec.data = wr ? wr_data : rd_data;
`else
    mem_cand     = wr;
    mem_rec.kind = 2'b01;
    mem_rec.data = wr_data;
`endif
    mem_rec.tag  = addr;
    // Register record always takes the first slot when present.
    rec0     = reg_cand ? reg_rec : mem_rec;
    ncand    = CW'(reg_cand) + CW'(mem_cand);
    free     = CW'(DEPTH) - count + CW'(pop);
    npush    = (free >= ncand) ? ncand : free;
    ndrop    = ncand - npush;
    drop_sum = {1'b0, drop_cnt} + 17'(ndrop);
  end

  // Pointer, occupancy and drop counter state.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      drop_cnt <= '0;
    end else begin
      wptr     <= wptr + PW'(npush);
      rptr     <= rptr + PW'(pop);
      count    <= count + npush - CW'(pop);
      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  // Record storage; second push of a cycle lands one slot past the write pointer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (npush != CW'(0)) mem[wptr] <= rec0;
      if (npush == CW'(2)) mem[wptr + PW'(1)] <= mem_rec;
    end
  end

endmodule

// File: tb/tb_commit_trace_fifo.sv
// Directed bench for commit_trace_fifo with immediate-assertion checks.
module tb_commit_trace_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        reg_write_sig;
  logic [4:0]  reg_num;
  logic [31:0] reg_data;
  logic        wr;
  logic        rd;
  logic [8:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        trc_valid;
  logic        trc_ready;
  logic [1:0]  trc_kind;
  logic [8:0]  trc_tag;
  logic [31:0] trc_data;
  logic        full;
  logic        empty;
  logic [4:0]  count;
  logic [15:0] drop_cnt;

  int checks = 0;
  int passed = 0;

  logic [1:0]  exp_kind [16];
  logic [8:0]  exp_tag  [16];
  logic [31:0] exp_data [16];

  commit_trace_fifo #(.DATA_W(32), .ADDR_W(9), .DEPTH(16)) dut (
    .clk(clk), .reset(reset),
    .reg_write_sig(reg_write_sig), .reg_num(reg_num), .reg_data(reg_data),
    .wr(wr), .rd(rd), .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
    .trc_valid(trc_valid), .trc_ready(trc_ready), .trc_kind(trc_kind),
    .trc_tag(trc_tag), .trc_data(trc_data), .full(full), .empty(empty),
    .count(count), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reg_write_sig = 1'b0; reg_num = '0; reg_data = '0;
    wr = 1'b0; rd = 1'b0; addr = '0; wr_data = '0; rd_data = '0;
  endtask

  task automatic drive_pair(input logic [4:0] rn, input logic [31:0] rdat,
                            input logic [8:0] a, input logic [31:0] wdat);
    reg_write_sig = 1'b1; reg_num = rn; reg_data = rdat;
    wr = 1'b1; addr = a; wr_data = wdat;
  endtask

  task automatic chk_head(input string tag, input logic [1:0] k,
                          input logic [8:0] t, input logic [31:0] d);
    chk({tag, "_valid"}, 64'(trc_valid), 64'(1));
    chk({tag, "_kind"},  64'(trc_kind),  64'(k));
    chk({tag, "_tag"},   64'(trc_tag),   64'(t));
    chk({tag, "_data"},  64'(trc_data),  64'(d));
  endtask

  initial begin
    idle();
    trc_ready = 1'b0;
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_empty", 64'(empty), 64'(1));
    chk("rst_full",  64'(full),  64'(0));
    chk("rst_valid", 64'(trc_valid), 64'(0));
    chk("rst_drop",  64'(drop_cnt), 64'(0));

    // Single register record, popped immediately.
    trc_ready = 1'b1;
    reg_write_sig = 1'b1; reg_num = 5'd5; reg_data = 32'hDEADBEEF;
    step(); idle();
    chk_head("t1", 2'b00, 9'd5, 32'hDEADBEEF);
    step();
    chk("t1_empty", 64'(empty), 64'(1));
    chk("t1_count", 64'(count), 64'(0));

    // Register and store in the same cycle: register first.
    trc_ready = 1'b0;
    drive_pair(5'd3, 32'h11, 9'h040, 32'h22);
    step(); idle();
    chk("t2_count", 64'(count), 64'(2));
    chk_head("t2a", 2'b00, 9'd3, 32'h11);
    trc_ready = 1'b1;
    step();
    chk_head("t2b", 2'b01, 9'h040, 32'h22);
    chk("t2_count1", 64'(count), 64'(1));
    step();
    chk("t2_empty", 64'(empty), 64'(1));

    // x0 writes are never recorded.
    trc_ready = 1'b0;
    reg_write_sig = 1'b1; reg_num = 5'd0; reg_data = 32'h1234;
    step(); idle();
    chk("t3_count", 64'(count), 64'(0));
    chk("t3_drop",  64'(drop_cnt), 64'(0));

    // Fill 16 with pairs, overflow 3 cycles, then drain across pointer wrap.
    for (int i = 0; i < 8; i++) begin
      exp_kind[2*i]   = 2'b00; exp_tag[2*i]   = 9'(i + 1);
      exp_data[2*i]   = 32'h100 + 32'(i);
      exp_kind[2*i+1] = 2'b01; exp_tag[2*i+1] = 9'h080 + 9'(i);
      exp_data[2*i+1] = 32'h200 + 32'(i);
      drive_pair(5'(i + 1), 32'h100 + 32'(i), 9'h080 + 9'(i), 32'h200 + 32'(i));
      step();
    end
    idle();
    chk("t4_full",  64'(full),  64'(1));
    chk("t4_count", 64'(count), 64'(16));
    for (int i = 0; i < 3; i++) begin
      drive_pair(5'd31, 32'hBAD, 9'h1AA, 32'hBAD);
      step();
    end
    idle();
    chk("t4_count_ovf", 64'(count), 64'(16));
    chk("t4_drop", 64'(drop_cnt), 64'(6));
    trc_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk_head($sformatf("t4_drain%0d", i), exp_kind[i], exp_tag[i], exp_data[i]);
      step();
    end
    chk("t4_empty", 64'(empty), 64'(1));

    // count=15 with a pop: both records fit, no drop.
    trc_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      drive_pair(5'd7, 32'(i), 9'h010, 32'(i));
      step();
    end
    idle();
    reg_write_sig = 1'b1; reg_num = 5'd9; reg_data = 32'h99;
    step(); idle();
    chk("t5_count15", 64'(count), 64'(15));
    trc_ready = 1'b1;
    drive_pair(5'd10, 32'hA, 9'h0AA, 32'hB);
    step(); idle();
    trc_ready = 1'b0;
    chk("t5_count", 64'(count), 64'(16));
    chk("t5_drop",  64'(drop_cnt), 64'(6));
    trc_ready = 1'b1;
    for (int i = 0; i < 16; i++) step();
    chk("t5_empty", 64'(empty), 64'(1));

    // Load record only when the load feature is built in.
    trc_ready = 1'b0;
    rd = 1'b1; addr = 9'h1FF; rd_data = 32'hCAFE0001;
    step(); idle();
`ifdef TRACE_LOAD_EN
    chk("t6_count", 64'(count), 64'(1));
    chk_head("t6", 2'b10, 9'h1FF, 32'hCAFE0001);
    trc_ready = 1'b1;
    step();
    trc_ready = 1'b0;
`else
    chk("t6_count", 64'(count), 64'(0));
`endif
    chk("t6_drop", 64'(drop_cnt), 64'(6));

    // Drop counter saturation.
    for (int i = 0; i < 8; i++) begin
      drive_pair(5'd1, 32'h1, 9'h001, 32'h1);
      step();
    end
    for (int i = 0; i < 32768; i++) step();
    chk("t7_sat", 64'(drop_cnt), 64'hFFFF);
    step(); idle();
    chk("t7_sat_hold", 64'(drop_cnt), 64'hFFFF);
    trc_ready = 1'b1;
    for (int i = 0; i < 16; i++) step();
    trc_ready = 1'b0;
    chk("t7_empty", 64'(empty), 64'(1));

    // Reset mid-operation with 5 records queued; candidates during reset ignored.
    drive_pair(5'd2, 32'h2, 9'h002, 32'h2); step();
    drive_pair(5'd2, 32'h2, 9'h002, 32'h2); step();
    idle(); reg_write_sig = 1'b1; reg_num = 5'd4; step(); idle();
    chk("t8_count5", 64'(count), 64'(5));
    reset = 1'b1;
    drive_pair(5'd6, 32'h6, 9'h006, 32'h6);
    step();
    reset = 1'b0; idle();
    chk("t8_count", 64'(count), 64'(0));
    chk("t8_valid", 64'(trc_valid), 64'(0));
    chk("t8_drop",  64'(drop_cnt), 64'(0));
    step();
    chk("t8_count_after", 64'(count), 64'(0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
